// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared encodings and constants for the local IO bus arbiter.
package io_bus_pkg;
  localparam int IO_ADDR_W = 16;
  localparam int IO_DATA_W = 8;
  localparam int GPIO_DEV = 0;
  localparam logic [IO_DATA_W-1:0] IO_ERR_DATA = 8'hFF;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} io_state_e;
  function automatic logic [7:0] dev_index(input logic [IO_ADDR_W-1:0] a);
    return a[15:8];
  endfunction
endpackage

// File: rtl/io_rr_arbiter.sv
// io_rr_arbiter: two-way round-robin grant; last-served pointer starts on m1 so m0 wins first.
module io_rr_arbiter (
  input  logic       clk,
  input  logic       reset_,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_o,
  output logic       valid_o
);
  logic last_q, last_d;
  always_comb begin
    valid_o = |req_i;
    gnt_o = (req_i == 2'b11) ? ~last_q : req_i[1];
    last_d = (take_i && valid_o) ? gnt_o : last_q;
  end
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) last_q <= 1'b1;
    else last_q <= last_d;
endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the 8-bit IO bus between two masters with address decode,
// req/rdy sequencing toward the peripherals and a timeout error response.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   m0_req,
  input  logic                   m0_rnw,
  input  logic [IO_ADDR_W-1:0]   m0_addr,
  input  logic [IO_DATA_W-1:0]   m0_wr_data,
  output logic [IO_DATA_W-1:0]   m0_rd_data,
  output logic                   m0_rdy,
  output logic                   m0_err,
  input  logic                   m1_req,
  input  logic                   m1_rnw,
  input  logic [IO_ADDR_W-1:0]   m1_addr,
  input  logic [IO_DATA_W-1:0]   m1_wr_data,
  output logic [IO_DATA_W-1:0]   m1_rd_data,
  output logic                   m1_rdy,
  output logic                   m1_err,
  output logic [7:0]             addr,
  output logic [NUM_DEV-1:0]     cs,
  output logic                   req,
  output logic                   rnw,
  output logic [IO_DATA_W-1:0]   wr_data,
  input  logic [8*NUM_DEV-1:0]   dev_rd_data,
  input  logic [NUM_DEV-1:0]     dev_rdy
);
  localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [7:0] NUM_DEV_B = 8'(NUM_DEV);
  io_state_e state_q;
  logic gnt_q, arb_gnt, arb_valid, take;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0] addr_q;
  logic [NUM_DEV-1:0] cs_q, cs_dec;
  logic req_q, rnw_q, sel_rnw, mapped, dev_hit, timeout;
  logic [IO_DATA_W-1:0] wr_data_q, sel_wdata, dev_data;
  logic [IO_ADDR_W-1:0] sel_addr;
  logic [7:0] dev_idx;
  logic [1:0] rdy_q, err_q;
  logic [IO_DATA_W-1:0] rd_data_q [2];
  io_rr_arbiter u_arb (
    .clk(clk), .reset_(reset_), .req_i({m1_req, m0_req}), .take_i(take),
    .gnt_o(arb_gnt), .valid_o(arb_valid)
  );
  always_comb begin
    take = state_q == IDLE;
    sel_addr = arb_gnt ? m1_addr : m0_addr;
    sel_rnw = arb_gnt ? m1_rnw : m0_rnw;
    sel_wdata = arb_gnt ? m1_wr_data : m0_wr_data;
    dev_idx = dev_index(sel_addr);
    mapped = dev_idx < NUM_DEV_B;
    cs_dec = '0;
    cs_dec[dev_idx[IDX_W-1:0]] = 1'b1;
    dev_hit = dev_rdy[idx_q];
    dev_data = dev_rd_data[{idx_q, 3'b000} +: IO_DATA_W];
    timeout = cnt_q == CNT_W'(TIMEOUT_CYC - 1);
  end
  // Outputs of the master not currently granted are never touched, so its rd_data holds.
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      state_q <= IDLE;
      gnt_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      cs_q <= '0;
      req_q <= 1'b0;
      rnw_q <= 1'b0;
      wr_data_q <= '0;
      rdy_q <= '0;
      err_q <= '0;
      rd_data_q <= '{default: '0};
    end else begin
      case (state_q)
        IDLE: if (arb_valid) begin
          gnt_q <= arb_gnt;
          if (mapped) begin
            addr_q <= sel_addr[7:0];
            rnw_q <= sel_rnw;
            wr_data_q <= sel_wdata;
            cs_q <= cs_dec;
            req_q <= 1'b1;
            idx_q <= dev_idx[IDX_W-1:0];
            cnt_q <= '0;
            state_q <= ACCESS;
          end else begin
            rdy_q[arb_gnt] <= 1'b1;
            err_q[arb_gnt] <= 1'b1;
            rd_data_q[arb_gnt] <= IO_ERR_DATA;
            state_q <= DONE;
          end
        end
        ACCESS: if (dev_hit) begin
          rdy_q[gnt_q] <= 1'b1;
          if (rnw_q) rd_data_q[gnt_q] <= dev_data;
          req_q <= 1'b0;
          cs_q <= '0;
          state_q <= DONE;
        end else if (timeout) begin
          rdy_q[gnt_q] <= 1'b1;
          err_q[gnt_q] <= 1'b1;
          rd_data_q[gnt_q] <= IO_ERR_DATA;
          req_q <= 1'b0;
          cs_q <= '0;
          state_q <= DONE;
        end else cnt_q <= cnt_q + 1'b1;
        DONE: begin
          rdy_q <= '0;
          err_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  always_comb begin
    addr = addr_q;
    cs = cs_q;
    req = req_q;
    rnw = rnw_q;
    wr_data = wr_data_q;
    m0_rdy = rdy_q[0];
    m1_rdy = rdy_q[1];
    m0_err = err_q[0];
    m1_err = err_q[1];
    m0_rd_data = rd_data_q[0];
    m1_rd_data = rd_data_q[1];
  end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed checks of io_bus_arbiter with a GPIO device model on dev0.
module tb_io_bus_arbiter;
  logic clk = 1'b0, reset_ = 1'b0;
  logic m0_req = 0, m0_rnw = 0, m1_req = 0, m1_rnw = 0;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic [7:0] m0_wr_data = '0, m1_wr_data = '0, m0_rd_data, m1_rd_data;
  logic m0_rdy, m0_err, m1_rdy, m1_err;
  logic [7:0] addr, wr_data;
  logic [3:0] cs, dev_rdy;
  logic req, rnw;
  logic [31:0] dev_rd_data;
  logic [7:0] leds;
  logic [6:0] switches = 7'h00;
  int passes = 0, total = 0;
  always #5 clk = ~clk;
  io_bus_arbiter dut (
    .clk(clk), .reset_(reset_),
    .m0_req(m0_req), .m0_rnw(m0_rnw), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_rd_data(m0_rd_data), .m0_rdy(m0_rdy), .m0_err(m0_err),
    .m1_req(m1_req), .m1_rnw(m1_rnw), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_rd_data(m1_rd_data), .m1_rdy(m1_rdy), .m1_err(m1_err),
    .addr(addr), .cs(cs), .req(req), .rnw(rnw), .wr_data(wr_data),
    .dev_rd_data(dev_rd_data), .dev_rdy(dev_rdy)
  );
  // dev0 is a GPIO block (reg 0 = leds, reg 1 = {switches,0}); dev1 never answers.
  always @(posedge clk or negedge reset_)
    if (!reset_) begin
      dev_rdy <= '0;
      leds <= '0;
    end else begin
      dev_rdy <= {req & cs[3], req & cs[2], 1'b0, req & cs[0]};
      if (req && cs[0] && !rnw && addr == 8'h00) leds <= wr_data;
    end
  assign dev_rd_data = {8'h33, 8'h22, 8'h11, (addr == 8'h01) ? {switches, 1'b0} : leds};
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic drive(input bit m, input bit on, input bit r, input logic [15:0] a, input logic [7:0] d);
    if (!m) begin
      m0_req = on; m0_rnw = r; m0_addr = a; m0_wr_data = d;
    end else begin
      m1_req = on; m1_rnw = r; m1_addr = a; m1_wr_data = d;
    end
  endtask
  task automatic wait_rdy(input bit m, input int bound, output int n);
    n = 0;
    while (!(m ? m1_rdy : m0_rdy) && n < bound) begin
      @(negedge clk);
      n = n + 1;
    end
    check("rdy_within_bound", 32'(n < bound), 32'd1);
  endtask
  initial begin
    int n, first, c0, c1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {req, cs, rnw, addr, wr_data, m0_rdy, m1_rdy, m0_err, m1_err}, '0);
    check("rst_rd_data", {m0_rd_data, m1_rd_data}, 16'h0000);
    reset_ = 1'b1;
    @(negedge clk);
    // 1: m0 write to GPIO
    drive(0, 1, 0, 16'h0000, 8'hA5);
    @(negedge clk);
    check("t1_bus_e0", {req, cs, rnw, addr, wr_data}, {1'b1, 4'b0001, 1'b0, 8'h00, 8'hA5});
    check("t1_rdy_e0", m0_rdy, 1'b0);
    @(negedge clk);
    check("t1_req_e1", {req, m0_rdy}, 2'b10);
    @(negedge clk);
    check("t1_done", {req, cs, m0_rdy, m0_err}, {1'b0, 4'b0000, 1'b1, 1'b0});
    check("t1_leds", leds, 8'hA5);
    drive(0, 0, 0, 16'h0000, 8'hA5);
    @(negedge clk);
    check("t1_rdy_drop", m0_rdy, 1'b0);
    @(negedge clk);
    // 2: m1 read of switches
    switches = 7'h55;
    drive(1, 1, 1, 16'h0001, 8'h00);
    @(negedge clk);
    check("t2_bus_e0", {req, cs, rnw, addr}, {1'b1, 4'b0001, 1'b1, 8'h01});
    @(negedge clk);
    @(negedge clk);
    check("t2_done", {m1_rdy, m1_err, m0_rdy}, 3'b100);
    check("t2_rd_data", m1_rd_data, 8'hAA);
    drive(1, 0, 1, 16'h0001, 8'h00);
    @(negedge clk);
    check("t2_rdy_drop", {m1_rdy, m0_rdy}, 2'b00);
    @(negedge clk);
    // 4: unmapped device
    drive(0, 1, 1, 16'h0700, 8'h00);
    @(negedge clk);
    check("t4_no_bus_e0", {req, cs}, 5'b0);
    wait_rdy(0, 4, n);
    check("t4_resp", {req, cs, m0_rdy, m0_err, m0_rd_data}, {1'b0, 4'b0, 1'b1, 1'b1, 8'hFF});
    drive(0, 0, 1, 16'h0700, 8'h00);
    @(negedge clk);
    check("t4_clear", {m0_rdy, m0_err}, 2'b00);
    @(negedge clk);
    // 5: timeout on dev1
    drive(1, 1, 1, 16'h0100, 8'h00);
    @(negedge clk);
    check("t5_cs", cs, 4'b0010);
    n = 0;
    while (req && n < 40) begin
      n = n + 1;
      @(negedge clk);
    end
    check("t5_req_cycles", n, 16);
    check("t5_resp", {req, cs, m1_rdy, m1_err, m1_rd_data}, {1'b0, 4'b0, 1'b1, 1'b1, 8'hFF});
    check("t5_m0_rd_hold", m0_rd_data, 8'hFF);
    drive(1, 0, 1, 16'h0100, 8'h00);
    @(negedge clk);
    check("t5_clear", {m1_rdy, m1_err}, 2'b00);
    @(negedge clk);
    // 3: simultaneous requests alternate
    for (int r = 0; r < 4; r++) begin
      first = -1; c0 = 0; c1 = 0;
      drive(0, 1, 0, 16'h0000, 8'(r));
      drive(1, 1, 1, 16'h0001, 8'h00);
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (m0_rdy) begin
          c0 = c0 + 1;
          if (first < 0) first = 0;
          m0_req = 1'b0;
        end
        if (m1_rdy) begin
          c1 = c1 + 1;
          if (first < 0) first = 1;
          m1_req = 1'b0;
        end
      end
      check("t3_first_m0", first, 0);
      check("t3_m0_once", c0, 1);
      check("t3_m1_once", c1, 1);
    end
    check("t3_leds", leds, 8'h03);
    // 6: async reset mid-access
    drive(0, 1, 0, 16'h0000, 8'h3C);
    @(negedge clk);
    check("t6_in_access", req, 1'b1);
    #1 reset_ = 1'b0;
    #1 check("t6_abort", {req, cs, m0_rdy, m1_rdy}, 7'b0);
    drive(0, 0, 0, 16'h0000, 8'h3C);
    @(negedge clk);
    check("t6_no_rdy", {req, m0_rdy}, 2'b00);
    reset_ = 1'b1;
    @(negedge clk);
    drive(0, 1, 0, 16'h0000, 8'h5A);
    wait_rdy(0, 10, n);
    check("t6_latency", n, 3);
    check("t6_resp", {m0_err, leds}, {1'b0, 8'h5A});
    drive(0, 0, 0, 16'h0000, 8'h5A);
    @(negedge clk);
    check("t6_clear", {m0_rdy, req}, 2'b00);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
